// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with arbitrary depth (>= 2), programmable
// almost-full / almost-empty levels, occupancy count and registered strobes.
// Every output is driven straight from a flop; status flags are registered
// from the next-state count so they always agree with the count output.
module sync_fifo_param #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_LEVEL   = FIFO_DEPTH - 1,
    parameter int AE_LEVEL   = 1,
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty,
    output logic [CNT_W-1:0]      count
);

    // Pointers only need to address FIFO_DEPTH entries; they wrap explicitly
    // at the last index, so the depth does not have to be a power of two.
    localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_LEVEL);

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr_next;
    logic [PTR_W-1:0]      rd_ptr_next;
    logic [CNT_W-1:0]      count_next;
    logic                  wr_accept;
    logic                  rd_accept;

    // Accept decisions and next-state pointers/count, all from pre-edge state.
    always_comb begin
        wr_accept   = 1'b0;
        rd_accept   = 1'b0;
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;
        count_next  = count;

        if (wr_en && (count != CNT_FULL)) begin
            wr_accept = 1'b1;
        end else begin
            wr_accept = 1'b0;
        end

        if (rd_en && (count != CNT_ZERO)) begin
            rd_accept = 1'b1;
        end else begin
            rd_accept = 1'b0;
        end

        if (wr_accept) begin
            if (wr_ptr == LAST_PTR) begin
                wr_ptr_next = '0;
            end else begin
                wr_ptr_next = wr_ptr + PTR_ONE;
            end
        end else begin
            wr_ptr_next = wr_ptr;
        end

        if (rd_accept) begin
            if (rd_ptr == LAST_PTR) begin
                rd_ptr_next = '0;
            end else begin
                rd_ptr_next = rd_ptr + PTR_ONE;
            end
        end else begin
            rd_ptr_next = rd_ptr;
        end

        case ({wr_accept, rd_accept})
            2'b10:   count_next = count + CNT_ONE;
            2'b01:   count_next = count - CNT_ONE;
            default: count_next = count;
        endcase
    end

    // Storage array; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_accept) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointer, count, read data, handshake pulses and status flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            data_out    <= '0;
            rd_valid    <= 1'b0;
            wr_ack      <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            full        <= 1'b0;
            empty       <= 1'b1;
            almostfull  <= 1'b0;
            almostempty <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr_next;
            rd_ptr    <= rd_ptr_next;
            count     <= count_next;
            rd_valid  <= rd_accept;
            wr_ack    <= wr_accept;
            overflow  <= wr_en && !wr_accept;
            underflow <= rd_en && !rd_accept;
            if (rd_accept) begin
                data_out <= mem[rd_ptr];
            end
            full        <= (count_next == CNT_FULL);
            empty       <= (count_next == CNT_ZERO);
            almostfull  <= (count_next >= AF_CNT) && (count_next != CNT_FULL);
            almostempty <= (count_next <= AE_CNT) && (count_next != CNT_ZERO);
        end
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: drives two FIFO instances (8-deep and 6-deep) and
// compares every output each cycle against a queue-based reference model.
module tb_sync_fifo_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 8-deep instance, default levels
    logic        rst8 = 1'b1, wr8 = 1'b0, rd8 = 1'b0;
    logic [15:0] din8 = 16'h0000;
    logic [15:0] dout8;
    logic        rv8, wack8, ovf8, udf8, full8, empty8, af8, ae8;
    logic [3:0]  cnt8;

    // 6-deep instance, AF_LEVEL=4, AE_LEVEL=2
    logic        rst6 = 1'b1, wr6 = 1'b0, rd6 = 1'b0;
    logic [15:0] din6 = 16'h0000;
    logic [15:0] dout6;
    logic        rv6, wack6, ovf6, udf6, full6, empty6, af6, ae6;
    logic [2:0]  cnt6;

    sync_fifo_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) dut8 (
        .clk(clk), .rst(rst8), .data_in(din8), .wr_en(wr8), .rd_en(rd8),
        .data_out(dout8), .rd_valid(rv8), .wr_ack(wack8), .overflow(ovf8),
        .underflow(udf8), .full(full8), .empty(empty8), .almostfull(af8),
        .almostempty(ae8), .count(cnt8)
    );

    sync_fifo_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(6), .AF_LEVEL(4), .AE_LEVEL(2)) dut6 (
        .clk(clk), .rst(rst6), .data_in(din6), .wr_en(wr6), .rd_en(rd6),
        .data_out(dout6), .rd_valid(rv6), .wr_ack(wack6), .overflow(ovf6),
        .underflow(udf6), .full(full6), .empty(empty6), .almostfull(af6),
        .almostempty(ae6), .count(cnt6)
    );

    int n_checks = 0;
    int n_errors = 0;

    // reference model state: stored words in order, and last value read out
    logic [15:0] q8[$];
    logic [15:0] q6[$];
    logic [15:0] exp_dout8 = 16'h0000;
    logic [15:0] exp_dout6 = 16'h0000;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle on the selected instance, followed by a full output check.
    task automatic step(input int sel, input bit r, input bit w, input bit rd, input logic [15:0] d);
        logic [15:0] mq[$];
        logic [15:0] edout;
        int depth, af_lvl, ae_lvl, sz;
        bit wa, ra, ov, ud;
        logic [31:0] o_cnt, o_dout;
        bit o_rv, o_wack, o_ovf, o_udf, o_full, o_empty, o_af, o_ae;
        string p;

        if (sel == 8) begin
            rst8 = r; wr8 = w; rd8 = rd; din8 = d;
            mq = q8; edout = exp_dout8; depth = 8; af_lvl = 7; ae_lvl = 1; p = "d8";
        end else begin
            rst6 = r; wr6 = w; rd6 = rd; din6 = d;
            mq = q6; edout = exp_dout6; depth = 6; af_lvl = 4; ae_lvl = 2; p = "d6";
        end

        @(posedge clk);
        if (r) begin
            mq.delete();
            edout = 16'h0000;
            wa = 1'b0; ra = 1'b0; ov = 1'b0; ud = 1'b0;
        end else begin
            ra = rd && (mq.size() > 0);
            wa = w && (mq.size() < depth);
            ov = w && !wa;
            ud = rd && !ra;
            if (ra) edout = mq.pop_front();
            if (wa) mq.push_back(d);
        end
        sz = mq.size();
        if (sel == 8) begin q8 = mq; exp_dout8 = edout; end
        else begin q6 = mq; exp_dout6 = edout; end

        @(negedge clk);
        if (sel == 8) begin
            o_cnt = 32'(cnt8); o_dout = 32'(dout8); o_rv = rv8; o_wack = wack8;
            o_ovf = ovf8; o_udf = udf8; o_full = full8; o_empty = empty8; o_af = af8; o_ae = ae8;
        end else begin
            o_cnt = 32'(cnt6); o_dout = 32'(dout6); o_rv = rv6; o_wack = wack6;
            o_ovf = ovf6; o_udf = udf6; o_full = full6; o_empty = empty6; o_af = af6; o_ae = ae6;
        end
        check_val({p, " count"},       o_cnt, 32'(sz));
        check_val({p, " data_out"},    o_dout, 32'(edout));
        check_val({p, " rd_valid"},    32'(o_rv), 32'(ra));
        check_val({p, " wr_ack"},      32'(o_wack), 32'(wa));
        check_val({p, " overflow"},    32'(o_ovf), 32'(ov));
        check_val({p, " underflow"},   32'(o_udf), 32'(ud));
        check_val({p, " full"},        32'(o_full), 32'(sz == depth));
        check_val({p, " empty"},       32'(o_empty), 32'(sz == 0));
        check_val({p, " almostfull"},  32'(o_af), 32'((sz >= af_lvl) && (sz < depth)));
        check_val({p, " almostempty"}, 32'(o_ae), 32'((sz > 0) && (sz <= ae_lvl)));
    endtask

    initial begin
        // ---- 8-deep instance (dut6 held in reset) ----
        repeat (2) step(8, 1'b1, 1'b0, 1'b0, 16'h0000);

        // fill past full: 8 accepted, 9th overflows
        for (int i = 0; i < 9; i++) step(8, 1'b0, 1'b1, 1'b0, 16'hA000 + 16'(i));
        // drain past empty: 8 reads in order, 9th underflows and data holds
        for (int i = 0; i < 9; i++) step(8, 1'b0, 1'b0, 1'b1, 16'h0000);

        // concurrent at mid occupancy
        for (int i = 0; i < 4; i++) step(8, 1'b0, 1'b1, 1'b0, 16'hB000 + 16'(i));
        step(8, 1'b0, 1'b1, 1'b1, 16'hB100);
        // concurrent at full
        for (int i = 0; i < 8 && q8.size() < 8; i++) step(8, 1'b0, 1'b1, 1'b0, 16'hC000 + 16'(i));
        step(8, 1'b0, 1'b1, 1'b1, 16'hC0FF);
        // concurrent at empty
        for (int i = 0; i < 8 && q8.size() > 0; i++) step(8, 1'b0, 1'b0, 1'b1, 16'h0000);
        step(8, 1'b0, 1'b1, 1'b1, 16'hD00D);

        // random traffic
        for (int i = 0; i < 150; i++)
            step(8, 1'b0, $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50, 16'($urandom));

        // reset in the middle of traffic with both requests raised
        step(8, 1'b1, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 5; i++) step(8, 1'b0, 1'b1, 1'b0, 16'hE000 + 16'(i));
        step(8, 1'b1, 1'b1, 1'b1, 16'h5555);
        step(8, 1'b0, 1'b0, 1'b0, 16'h0000);
        rst8 = 1'b1;

        // ---- 6-deep instance: non-power-of-two wrap ----
        repeat (2) step(6, 1'b1, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 240; i++) begin
            int wp;
            if (i < 60)       wp = 75;
            else if (i < 120) wp = 25;
            else              wp = 50;
            step(6, 1'b0, $urandom_range(0, 99) < wp, $urandom_range(0, 99) < (100 - wp), 16'($urandom));
        end
        step(6, 1'b1, 1'b1, 1'b1, 16'h1234);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
